bram_arbiter: RTL

- Two-requester, single-clock arbiter and sequencer for the 8K x 1 simple-dual-port block RAM.
- Accepts at most one read or write per cycle from port A or port B, using round-robin priority.
- Drives the BRAM read and write ports and returns read data with a fixed latency, tagged to the requester.
- Also provides a CLEAR sweep that writes 0 to every address. The BRAM RDCLK and WRCLK are both tied to CLK at the top level.

---
 rtl/bram_arbiter_pkg.sv | 17 +
 rtl/bram_arbiter_rd_pipe.sv | 41 ++++
 rtl/bram_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared encodings and default widths for the block-RAM arbiter.
package bram_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 13;
   localparam int unsigned DATA_W_DEF = 1;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef enum logic {
      TAG_A = 1'b0,
      TAG_B = 1'b1
   } tag_t;

endpackage

// File: rtl/bram_arbiter_rd_pipe.sv
// Valid/tag shift register tracking reads in flight through the BRAM.
module bram_rd_pipe
   import bram_arbiter_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  tag_t       push_tag,
   output logic [1:0] rvalid_en
);

   localparam int unsigned DEPTH = 1 + READ_LATENCY;

   logic [DEPTH-1:0] vld_q;
   tag_t             tag_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= TAG_A;
         end
      end else begin
         vld_q    <= {vld_q[DEPTH-2:0], push};
         tag_q[0] <= push_tag;
         for (int i = 1; i < DEPTH; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Last stage lines up with BRAM_DO for that read; decode to a per-requester enable.
   always_comb begin
      rvalid_en    = 2'b00;
      rvalid_en[0] = vld_q[DEPTH-1] && (tag_q[DEPTH-1] == TAG_A);
      rvalid_en[1] = vld_q[DEPTH-1] && (tag_q[DEPTH-1] == TAG_B);
   end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin two-port arbiter and clear sequencer in front of an SDP block RAM.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ_A,
   input  logic              REQ_B,
   input  logic              WE_A,
   input  logic              WE_B,
   input  logic [ADDR_W-1:0] ADDR_A,
   input  logic [ADDR_W-1:0] ADDR_B,
   input  logic [DATA_W-1:0] WDATA_A,
   input  logic [DATA_W-1:0] WDATA_B,
   output logic              GNT_A,
   output logic              GNT_B,
   output logic              RVALID_A,
   output logic              RVALID_B,
   output logic [DATA_W-1:0] RDATA_A,
   output logic [DATA_W-1:0] RDATA_B,
   input  logic              CLEAR,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] BRAM_RDADDR,
   output logic [ADDR_W-1:0] BRAM_WRADDR,
   output logic [DATA_W-1:0] BRAM_DI,
   output logic              BRAM_WE,
   output logic              BRAM_WREN,
   output logic              BRAM_RDEN,
   output logic              BRAM_REGCE,
   output logic              BRAM_RST,
   input  logic [DATA_W-1:0] BRAM_DO
);

   state_t              state_q, state_d;
   tag_t                last_q, sel_tag;
   logic [ADDR_W-1:0]   clr_cnt_q, rdaddr_q, wraddr_q, sel_addr;
   logic [DATA_W-1:0]   di_q, sel_wdata, rdata_a_q, rdata_b_q;
   logic                wren_q, rden_q, done_q, bram_rst_q, rvalid_a_q, rvalid_b_q;
   logic                gnt_a, gnt_b, accept, sel_we, push;
   logic [1:0]          rvalid_en;

   always_comb begin
      gnt_a     = RST_N && (state_q == ST_RUN) && REQ_A && (!REQ_B || (last_q != TAG_A));
      gnt_b     = RST_N && (state_q == ST_RUN) && REQ_B && (!REQ_A || (last_q != TAG_B));
      accept    = gnt_a || gnt_b;
      sel_we    = gnt_a ? WE_A    : WE_B;
      sel_addr  = gnt_a ? ADDR_A  : ADDR_B;
      sel_wdata = gnt_a ? WDATA_A : WDATA_B;
      sel_tag   = gnt_a ? TAG_A   : TAG_B;
      push      = accept && !sel_we;

      state_d = state_q;
      unique case (state_q)
         ST_RUN:   if (CLEAR) state_d = ST_CLEAR;
         ST_CLEAR: if (clr_cnt_q == '1) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_RUN;
         last_q     <= TAG_B;
         clr_cnt_q  <= '0;
         rdaddr_q   <= '0;
         wraddr_q   <= '0;
         di_q       <= '0;
         wren_q     <= 1'b0;
         rden_q     <= 1'b0;
         done_q     <= 1'b0;
         bram_rst_q <= 1'b1;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         state_q    <= state_d;
         bram_rst_q <= 1'b0;
         done_q     <= (state_q == ST_CLEAR) && (state_d == ST_RUN);
         wren_q     <= 1'b0;
         rden_q     <= 1'b0;
         if (accept) last_q <= sel_tag;

         // The sweep owns the write port; the counter wraps to 0 on its last address.
         if (state_q == ST_CLEAR) begin
            wren_q    <= 1'b1;
            wraddr_q  <= clr_cnt_q;
            di_q      <= '0;
            clr_cnt_q <= ADDR_W'(clr_cnt_q + 1'b1);
         end else if (accept) begin
            if (sel_we) begin
               wren_q   <= 1'b1;
               wraddr_q <= sel_addr;
               di_q     <= sel_wdata;
            end else begin
               rden_q   <= 1'b1;
               rdaddr_q <= sel_addr;
            end
         end

         rvalid_a_q <= rvalid_en[0];
         rvalid_b_q <= rvalid_en[1];
         if (rvalid_en[0]) rdata_a_q <= BRAM_DO;
         if (rvalid_en[1]) rdata_b_q <= BRAM_DO;
      end
   end

   bram_rd_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_rd_pipe (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (push),
      .push_tag (sel_tag),
      .rvalid_en(rvalid_en)
   );

   assign GNT_A       = gnt_a;
   assign GNT_B       = gnt_b;
   assign RVALID_A    = rvalid_a_q;
   assign RVALID_B    = rvalid_b_q;
   assign RDATA_A     = rdata_a_q;
   assign RDATA_B     = rdata_b_q;
   assign BUSY        = (state_q == ST_CLEAR);
   assign DONE        = done_q;
   assign BRAM_RDADDR = rdaddr_q;
   assign BRAM_WRADDR = wraddr_q;
   assign BRAM_DI     = di_q;
   assign BRAM_WE     = wren_q;
   assign BRAM_WREN   = wren_q;
   assign BRAM_RDEN   = rden_q;
   assign BRAM_REGCE  = (READ_LATENCY == 2);
   assign BRAM_RST    = bram_rst_q;

endmodule
